keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Drives and samples a 4x4 matrix keypad, debounces it, and presents one key
//  code to the time/timer setting master.
//  Sits between the board keypad pins and master.key_code:
//  - key_code holds the pressed key while it is pressed.
//  - key_code returns to 0 on release.
//  - master acts on 0 -> nonzero transitions only.
//  Code map: key_code = 4*col + row + 1 (1..16); 0 = no key.
// PARAMETERS
//  SCAN_DIV      1000  mclk cycles each column is driven (dwell), >= 2
//  DEBOUNCE_CNT  4     consecutive identical full scans to accept a change, 1..255
// PORTS
//  mclk      in   1  system clock; all state on rising edge
//  rst       in   1  asynchronous, active-high reset
//  row_in    in   4  keypad rows, active-low (board pull-ups), asynchronous to mclk
//  col_out   out  4  keypad columns, active-low; exactly one bit low at all times
//  key_code  out  6  debounced key code, 0 = none, 1..16 = key; bits [5:5] always 0
//  key_strobe out 1  one-cycle pulse when key_code changes to a nonzero value
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - col_out=4'b1110 (col 0), key_code=0, key_strobe=0.
//   - dwell counter, column index, debounce counter and scan accumulators = 0.
//   - FSM = RELEASED.
//   - Reset mid-scan or mid-debounce discards all partial state.
//  Input sync: row_in passes through a 2-flop synchronizer before any use.
//  Scan:
//   - Dwell counter counts 0..SCAN_DIV-1.
//   - At count SCAN_DIV-1: sample synced rows for the current column, then
//     advance column 0->1->2->3->0.
//   - col_out = ~(4'b0001 << col).
//   - Full scan = 4*SCAN_DIV cycles and ends at the column-3 sample.
//  Per-scan raw result:
//   - Accumulate the count of low rows and the code of the first low
//     (col, row) found, lowest row first within a column.
//   - At scan end: raw = code if exactly one key is seen.
//   - raw = 0 if no key or if 2+ keys are seen (multi-press/ghosting = none).
//   - Accumulators clear for the next scan.
//  Debounce FSM (evaluated once per scan end):
//   - RELEASED:  raw!=0 -> PRESS_PEND, cand=raw, cnt=1.
//   - PRESS_PEND:
//     - raw==cand -> cnt++.
//     - raw!=0, different -> cand=raw, cnt=1.
//     - raw==0 -> RELEASED.
//   - PRESSED:   raw!=key_code -> CHANGE_PEND, cand=raw, cnt=1.
//   - CHANGE_PEND:
//     - raw==cand -> cnt++.
//     - raw==key_code -> PRESSED.
//     - otherwise cand=raw, cnt=1.
//   - Acceptance: when cnt reaches DEBOUNCE_CNT, key_code<=cand in the cycle
//     after that scan end. Next state is PRESSED if cand!=0, else RELEASED.
//   - DEBOUNCE_CNT=1: a change is accepted at the first scan end that shows it.
//  key_strobe:
//   - High for exactly the cycle key_code takes a new nonzero value, including
//     a direct A->B change.
//   - Never high on release (->0).
//   - Never high when the accepted value equals the old one.
//  Latency, stable press to key_code:
//   - Between (DEBOUNCE_CNT-1)*4*SCAN_DIV+1 and DEBOUNCE_CNT*4*SCAN_DIV+3
//     cycles.
//   - This window includes the 2 synchronizer cycles.
//   - Release latency is the same.
//  Counters use the widths needed for SCAN_DIV-1 and DEBOUNCE_CNT; the
//  debounce counter saturates and never wraps.
// TESTING  (SCAN_DIV=4, DEBOUNCE_CNT=2; the bench models row_in low only
//  while the pressed key's column is driven low)
//  1 Reset held, then released:
//    col_out=1110, key_code=0, key_strobe=0.
//    col_out steps 1101, 1011, 0111, 1110 every 4 cycles.
//  2 Press col1 row2, hold:
//    key_code=7 after 2 full scans (<=35 cycles); key_strobe high 1 cycle.
//    key_code stays 7 while held.
//  3 Press col3 row3 for one scan only, then release:
//    key_code stays 0, key_strobe never pulses.
//  4 Hold col0 row0 and col2 row1 together:
//    key_code stays 0.
//    Releasing col2 leaves col0 row0 -> key_code=1 after 2 scans, one strobe.
//  5 From key_code=7, change directly to col3 row3:
//    key_code=16, one strobe.
//    Then release -> key_code=0 after 2 scans, no strobe.
//  6 Assert rst mid-debounce (1 scan into a press):
//    all outputs return to reset values immediately (async).
//    After release, the press needs a fresh 2 scans.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces the result and presents a
// single key code to the setting master.
//
// Ports:
//   mclk       system clock, all state on the rising edge
//   rst        asynchronous, active-high reset
//   row_in     keypad rows, active-low, asynchronous to mclk
//   col_out    keypad columns, active-low, exactly one bit low at all times
//   key_code   debounced key code: 0 = none, 1..16 = 4*col + row + 1
//   key_strobe one-cycle pulse when key_code takes a new nonzero value
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [5:0] key_code,
  output logic       key_strobe
);

  localparam int unsigned DwellW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW   = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0]   CntAccept = CntW'(DEBOUNCE_CNT);
  localparam logic [CntW-1:0]   CntOne    = CntW'(1);

  typedef enum logic [1:0] {
    StReleased,
    StPressPend,
    StPressed,
    StChangePend
  } state_e;

  // Row synchronizer; idles high because the board pulls the rows up.
  logic [3:0] row_meta_q, row_sync_q;

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= row_in;
      row_sync_q <= row_meta_q;
    end
  end

  // Column dwell timing
  logic [DwellW-1:0] dwell_q;
  logic [1:0]        col_q;
  logic              sample;
  logic              scan_end;

  assign sample   = (dwell_q == DwellLast);
  assign scan_end = sample && (col_q == 2'd3);

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      dwell_q <= '0;
      col_q   <= 2'd0;
    end else if (sample) begin
      dwell_q <= '0;
      col_q   <= col_q + 2'd1;
    end else begin
      dwell_q <= dwell_q + DwellW'(1);
    end
  end

  assign col_out = ~(4'b0001 << col_q);

  // Per-column decode: number of low rows and the code of the lowest low row
  logic [3:0] row_low;
  logic [2:0] col_hits;
  logic [4:0] col_code;

  assign row_low = ~row_sync_q;

  always_comb begin
    col_hits = 3'($countones(row_low));
    col_code = 5'd0;
    // Walk downward so the lowest low row is the last one written.
    for (int r = 3; r >= 0; r--) begin
      if (row_low[r]) begin
        col_code = 5'({col_q, 2'(r)}) + 5'd1;
      end
    end
  end

  // Scan accumulators; the hit count saturates at 2 since only 0/1/many matters.
  logic [1:0] hits_q;
  logic [4:0] first_q;
  logic [3:0] hits_sum;
  logic [1:0] hits_tot;
  logic [4:0] first_next;
  logic [4:0] raw;

  always_comb begin
    hits_sum   = 4'(hits_q) + 4'(col_hits);
    hits_tot   = (hits_sum >= 4'd2) ? 2'd2 : hits_sum[1:0];
    first_next = (first_q != 5'd0) ? first_q : col_code;
    // Only meaningful at scan_end: a single key gives its code, none or ghosting gives 0.
    raw        = (hits_tot == 2'd1) ? first_next : 5'd0;
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      hits_q  <= 2'd0;
      first_q <= 5'd0;
    end else if (scan_end) begin
      hits_q  <= 2'd0;
      first_q <= 5'd0;
    end else if (sample) begin
      hits_q  <= hits_tot;
      first_q <= first_next;
    end
  end

  // Debounce FSM, evaluated once per scan end
  state_e          state_q, state_d;
  logic [4:0]      cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [4:0]      key_q, key_d;
  logic            strobe_q, strobe_d;

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    strobe_d = 1'b0;
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CntOne;

    if (scan_end) begin
      unique case (state_q)
        StReleased: begin
          if (raw != 5'd0) begin
            state_d = StPressPend;
            cand_d  = raw;
            cnt_d   = CntOne;
          end
        end
        StPressPend: begin
          if (raw == 5'd0) begin
            state_d = StReleased;
            cand_d  = 5'd0;
            cnt_d   = '0;
          end else if (raw == cand_q) begin
            cnt_d = cnt_inc;
          end else begin
            cand_d = raw;
            cnt_d  = CntOne;
          end
        end
        StPressed: begin
          if (raw != key_q) begin
            state_d = StChangePend;
            cand_d  = raw;
            cnt_d   = CntOne;
          end
        end
        StChangePend: begin
          if (raw == cand_q) begin
            cnt_d = cnt_inc;
          end else if (raw == key_q) begin
            state_d = StPressed;
            cnt_d   = '0;
          end else begin
            cand_d = raw;
            cnt_d  = CntOne;
          end
        end
        default: begin
          state_d = StReleased;
          cnt_d   = '0;
        end
      endcase

      // Candidate held long enough: commit it (cnt is nonzero only in the pending states).
      if (cnt_d == CntAccept) begin
        key_d    = cand_d;
        strobe_d = (cand_d != 5'd0) && (cand_d != key_q);
        state_d  = (cand_d != 5'd0) ? StPressed : StReleased;
        cnt_d    = '0;
      end
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q  <= StReleased;
      cand_q   <= 5'd0;
      cnt_q    <= '0;
      key_q    <= 5'd0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      key_q    <= key_d;
      strobe_q <= strobe_d;
    end
  end

  assign key_code   = {1'b0, key_q};
  assign key_strobe = strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=2.
// A keypad model pulls a row low only while the pressed key's column is driven low. Expected
// strobe codes are queued when stimulus is applied and popped when key_strobe fires.
module tb_keypad_scanner;

  logic       mclk;
  logic       rst;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [5:0] key_code;
  logic       key_strobe;

  logic [15:0] keys;  // bit index = 4*col + row

  keypad_scanner #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CNT(2)
  ) dut (
    .mclk      (mclk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_strobe(key_strobe)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Keypad matrix model
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (keys[c*4+r] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  // Strobe scoreboard
  logic [5:0] exp_q[$];
  int strobe_cnt = 0;

  always @(negedge mclk) begin
    if (key_strobe) begin
      strobe_cnt++;
      if (exp_q.size() == 0) check("strobe_unexpected", exp_q.size(), 1);
      else check("strobe_code", int'(key_code), int'(exp_q.pop_front()));
    end
  end

  typedef struct {
    logic [15:0] keys;
    int          cycles;
    logic [5:0]  exp_code;
    int          exp_strobes;
    string       name;
  } vec_t;

  vec_t       vecs[12];
  logic [3:0] colseq[4];

  initial begin
    rst  = 1'b1;
    keys = 16'h0000;

    colseq[0] = 4'b1110;
    colseq[1] = 4'b1101;
    colseq[2] = 4'b1011;
    colseq[3] = 4'b0111;

    // Every duration is a whole number of 16-cycle scans, so stimulus changes at a scan start.
    vecs[0]  = '{keys: 16'h0000, cycles: 32, exp_code: 6'd0,  exp_strobes: 0, name: "idle"};
    vecs[1]  = '{keys: 16'h0040, cycles: 48, exp_code: 6'd7,  exp_strobes: 1, name: "press_c1r2"};
    vecs[2]  = '{keys: 16'h0040, cycles: 48, exp_code: 6'd7,  exp_strobes: 0, name: "hold_c1r2"};
    vecs[3]  = '{keys: 16'h0000, cycles: 48, exp_code: 6'd0,  exp_strobes: 0, name: "release1"};
    vecs[4]  = '{keys: 16'h8000, cycles: 16, exp_code: 6'd0,  exp_strobes: 0, name: "blip_c3r3"};
    vecs[5]  = '{keys: 16'h0000, cycles: 48, exp_code: 6'd0,  exp_strobes: 0, name: "after_blip"};
    vecs[6]  = '{keys: 16'h0201, cycles: 48, exp_code: 6'd0,  exp_strobes: 0, name: "two_keys"};
    vecs[7]  = '{keys: 16'h0001, cycles: 48, exp_code: 6'd1,  exp_strobes: 1, name: "drop_c2"};
    vecs[8]  = '{keys: 16'h0000, cycles: 48, exp_code: 6'd0,  exp_strobes: 0, name: "release2"};
    vecs[9]  = '{keys: 16'h0040, cycles: 48, exp_code: 6'd7,  exp_strobes: 1, name: "press_again"};
    vecs[10] = '{keys: 16'h8000, cycles: 48, exp_code: 6'd16, exp_strobes: 1, name: "change_c3r3"};
    vecs[11] = '{keys: 16'h0000, cycles: 48, exp_code: 6'd0,  exp_strobes: 0, name: "release3"};

    // Reset state
    repeat (3) @(negedge mclk);
    check("rst_col_out", int'(col_out), 4'b1110);
    check("rst_key_code", int'(key_code), 0);
    check("rst_key_strobe", int'(key_strobe), 0);

    // Column rotation after reset release
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("col_step%0d", i), int'(col_out), int'(colseq[i%4]));
      if (i < 4) repeat (4) @(negedge mclk);
    end

    // Table-driven key sequences
    for (int i = 0; i < 12; i++) begin
      keys       = vecs[i].keys;
      strobe_cnt = 0;
      if (vecs[i].exp_strobes > 0) exp_q.push_back(vecs[i].exp_code);
      repeat (vecs[i].cycles) @(negedge mclk);
      check({vecs[i].name, "_code"}, int'(key_code), int'(vecs[i].exp_code));
      check({vecs[i].name, "_strobes"}, strobe_cnt, vecs[i].exp_strobes);
    end

    // Reset one scan into a press
    keys       = 16'h0040;
    strobe_cnt = 0;
    repeat (20) @(negedge mclk);
    check("mid_debounce_code", int'(key_code), 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_col_out", int'(col_out), 4'b1110);
    check("async_rst_key_code", int'(key_code), 0);
    check("async_rst_key_strobe", int'(key_strobe), 0);
    repeat (2) @(negedge mclk);
    rst = 1'b0;
    exp_q.push_back(6'd7);
    repeat (20) @(negedge mclk);
    check("post_rst_early_code", int'(key_code), 0);
    check("post_rst_early_strobes", strobe_cnt, 0);
    repeat (20) @(negedge mclk);
    check("post_rst_code", int'(key_code), 7);
    check("post_rst_strobes", strobe_cnt, 1);

    check("strobe_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
